// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared types and helpers for the CPU bus arbiter: FSM state codes,
// bus owner codes, watchdog width and the round-robin pick function.
package cpu_bus_arbiter_pkg;

    // Arbiter sequencing states; the fourth 2-bit code is unused and recovers to idle.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BEGIN = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    // Which requester currently owns (or last owned) the external bus.
    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    // Watchdog counter width; TIMEOUT must fit in it (1..255).
    localparam int unsigned WDOG_W = 8;

    // Round-robin pick: a lone requester wins; on a tie the one that did
    // not finish last wins. Result is only meaningful when a request exists.
    function automatic owner_e pick_owner(input logic   f_req,
                                          input logic   d_req,
                                          input owner_e last_grant);
        owner_e win;
        if (f_req && d_req) begin
            win = (last_grant == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
        end else if (d_req) begin
            win = OWN_DATA;
        end else begin
            win = OWN_FETCH;
        end
        return win;
    endfunction

endpackage

// File: rtl/cpu_bus_arbiter_watchdog.sv
// Transfer watchdog: counts WAIT cycles and flags the cycle in which the
// count reaches TIMEOUT-1 so the arbiter can abort a hung bus transfer.
module cpu_bus_watchdog
    import cpu_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [WDOG_W-1:0] EXPIRE_AT = WDOG_W'(TIMEOUT - 1);
    localparam logic [WDOG_W-1:0] CNT_MAX   = {WDOG_W{1'b1}};
    localparam logic [WDOG_W-1:0] CNT_ONE   = WDOG_W'(1);

    logic [WDOG_W-1:0] cnt_q;
    logic [WDOG_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up while enabled and saturate.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = {WDOG_W{1'b0}};
        end else if (enable_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {WDOG_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = enable_i && (cnt_q == EXPIRE_AT);

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Two-port CPU bus arbiter: shares one memory/IO bus between instruction
// fetch (f) and load/store data (d), running the begin/wait/ready handshake
// for the granted requester with round-robin fairness and a watchdog abort.
module cpu_bus_arbiter
    import cpu_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_read,
    input  logic [ADDR_W-1:0] f_addr,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_done,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              bus_err
);

    arb_state_e        state_q;
    owner_e            owner_q;
    owner_e            last_grant_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] f_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              f_done_q;
    logic              d_done_q;
    logic              bus_err_q;

    logic              f_req_s;
    logic              d_req_s;
    logic              any_req_s;
    owner_e            grant_owner_s;
    logic              grant_write_s;
    logic [ADDR_W-1:0] grant_addr_s;
    logic [DATA_W-1:0] grant_wdata_s;
    logic              wd_clear_s;
    logic              wd_enable_s;
    logic              wd_expire_s;

    assign f_req_s       = f_read;
    assign d_req_s       = d_read | d_write;
    assign any_req_s     = f_req_s | d_req_s;
    assign grant_owner_s = pick_owner(f_req_s, d_req_s, last_grant_q);

    // Transfer parameters of the would-be winner; a data write beats a data read.
    always_comb begin
        grant_write_s = 1'b0;
        grant_addr_s  = f_addr;
        grant_wdata_s = {DATA_W{1'b0}};
        if (grant_owner_s == OWN_DATA) begin
            grant_write_s = d_write;
            grant_addr_s  = d_addr;
            grant_wdata_s = d_wdata;
        end else begin
            grant_write_s = 1'b0;
            grant_addr_s  = f_addr;
            grant_wdata_s = {DATA_W{1'b0}};
        end
    end

    // The watchdog only runs in WAIT and restarts from zero on every other state.
    always_comb begin
        wd_enable_s = 1'b0;
        wd_clear_s  = 1'b1;
        if (state_q == ARB_WAIT) begin
            wd_enable_s = 1'b1;
            wd_clear_s  = 1'b0;
        end else begin
            wd_enable_s = 1'b0;
            wd_clear_s  = 1'b1;
        end
    end

    cpu_bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (wd_clear_s),
        .enable_i (wd_enable_s),
        .expire_o (wd_expire_s)
    );

    // Arbiter FSM with all bus and CPU-side outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_FETCH;
            last_grant_q <= OWN_FETCH;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_wdata_q  <= {DATA_W{1'b0}};
            f_rdata_q    <= {DATA_W{1'b0}};
            d_rdata_q    <= {DATA_W{1'b0}};
            f_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            f_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            bus_err_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (any_req_s) begin
                        owner_q     <= grant_owner_s;
                        mem_read_q  <= ~grant_write_s;
                        mem_write_q <= grant_write_s;
                        mem_addr_q  <= grant_addr_s;
                        mem_wdata_q <= grant_wdata_s;
                        state_q     <= ARB_BEGIN;
                    end else begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        state_q     <= ARB_IDLE;
                    end
                end
                ARB_BEGIN: begin
                    state_q <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (mem_ready) begin
                        if (owner_q == OWN_DATA) begin
                            d_rdata_q <= mem_rdata;
                            d_done_q  <= 1'b1;
                        end else begin
                            f_rdata_q <= mem_rdata;
                            f_done_q  <= 1'b1;
                        end
                        mem_read_q   <= 1'b0;
                        mem_write_q  <= 1'b0;
                        last_grant_q <= owner_q;
                        state_q      <= ARB_IDLE;
                    end else if (wd_expire_s) begin
                        if (owner_q == OWN_DATA) begin
                            d_rdata_q <= {DATA_W{1'b0}};
                            d_done_q  <= 1'b1;
                        end else begin
                            f_rdata_q <= {DATA_W{1'b0}};
                            f_done_q  <= 1'b1;
                        end
                        bus_err_q    <= 1'b1;
                        mem_read_q   <= 1'b0;
                        mem_write_q  <= 1'b0;
                        last_grant_q <= owner_q;
                        state_q      <= ARB_IDLE;
                    end else begin
                        state_q <= ARB_WAIT;
                    end
                end
                default: begin
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    state_q     <= ARB_IDLE;
                end
            endcase
        end
    end

    assign f_rdata   = f_rdata_q;
    assign f_done    = f_done_q;
    assign d_rdata   = d_rdata_q;
    assign d_done    = d_done_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Self-checking bench for cpu_bus_arbiter: directed scenarios followed by
// random traffic, every cycle compared against a transaction-level model.
module tb_cpu_bus_arbiter;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              reset;
    logic              f_read;
    logic [ADDR_W-1:0] f_addr;
    logic [DATA_W-1:0] f_rdata;
    logic              f_done;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              bus_err;

    cpu_bus_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .f_read    (f_read),
        .f_addr    (f_addr),
        .f_rdata   (f_rdata),
        .f_done    (f_done),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int rd_hi  = 0;
    int wr_hi  = 0;

    // Transaction-level model: a transfer is "busy" from the grant edge on,
    // with m_age counting cycles since grant (1 = begin cycle, 1+k = k-th wait cycle).
    bit          m_busy;
    bit          m_owner;   // 0 = fetch, 1 = data
    bit          m_write;
    bit          m_last;    // owner of the last completed transfer
    int          m_age;
    bit          e_rd, e_wr, e_fdone, e_ddone, e_err;
    logic [15:0] e_addr, e_wdata, e_frd, e_drd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic finish_xfer(input logic [15:0] rd, input bit err);
        e_rd = 1'b0;
        e_wr = 1'b0;
        e_err = err;
        if (m_owner) begin
            e_ddone = 1'b1;
            e_drd   = rd;
        end else begin
            e_fdone = 1'b1;
            e_frd   = rd;
        end
        m_last = m_owner;
        m_busy = 1'b0;
    endtask

    task automatic model_step();
        bit fr, dr, own;
        e_fdone = 1'b0;
        e_ddone = 1'b0;
        e_err   = 1'b0;
        if (reset) begin
            m_busy = 1'b0; m_last = 1'b0; m_age = 0; m_owner = 1'b0; m_write = 1'b0;
            e_rd = 1'b0; e_wr = 1'b0;
            e_addr = 16'h0; e_wdata = 16'h0; e_frd = 16'h0; e_drd = 16'h0;
        end else if (!m_busy) begin
            fr = f_read;
            dr = d_read | d_write;
            if (fr || dr) begin
                own     = (fr && dr) ? ~m_last : dr;
                m_owner = own;
                m_busy  = 1'b1;
                m_age   = 1;
                m_write = own & d_write;
                e_rd    = ~m_write;
                e_wr    = m_write;
                e_addr  = own ? d_addr : f_addr;
                e_wdata = own ? d_wdata : 16'h0;
            end else begin
                e_rd = 1'b0;
                e_wr = 1'b0;
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (mem_ready) begin
            finish_xfer(mem_rdata, 1'b0);
        end else if (m_age - 1 >= TIMEOUT) begin
            finish_xfer(16'h0, 1'b1);
        end else begin
            m_age++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("mem_read",  {31'd0, mem_read},  {31'd0, e_rd});
        chk("mem_write", {31'd0, mem_write}, {31'd0, e_wr});
        chk("mem_addr",  {16'd0, mem_addr},  {16'd0, e_addr});
        chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, e_wdata});
        chk("f_done",    {31'd0, f_done},    {31'd0, e_fdone});
        chk("d_done",    {31'd0, d_done},    {31'd0, e_ddone});
        chk("bus_err",   {31'd0, bus_err},   {31'd0, e_err});
        chk("f_rdata",   {16'd0, f_rdata},   {16'd0, e_frd});
        chk("d_rdata",   {16'd0, d_rdata},   {16'd0, e_drd});
        if (mem_read)  rd_hi++;
        if (mem_write) wr_hi++;
    endtask

    initial begin
        int       n;
        int       ndone;
        bit [3:0] seq;

        reset = 1'b1; f_read = 1'b0; f_addr = 16'h0; d_read = 1'b0; d_write = 1'b0;
        d_addr = 16'h0; d_wdata = 16'h0; mem_rdata = 16'h0; mem_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Fetch read, ready on the second wait cycle.
        f_read = 1'b1; f_addr = 16'h0010; rd_hi = 0; wr_hi = 0;
        tick(); tick(); tick();
        mem_ready = 1'b1; mem_rdata = 16'h1234;
        tick();
        chk("t1_f_done",  {31'd0, f_done},  32'd1);
        chk("t1_f_rdata", {16'd0, f_rdata}, 32'h1234);
        chk("t1_d_done",  {31'd0, d_done},  32'd0);
        f_read = 1'b0; mem_ready = 1'b0;
        tick();
        chk("t1_rd_cycles", rd_hi, 32'd3);

        // Data write, ready immediately.
        d_write = 1'b1; d_addr = 16'h8000; d_wdata = 16'hBEEF; mem_ready = 1'b1;
        rd_hi = 0; wr_hi = 0;
        tick();
        chk("t2_addr",  {16'd0, mem_addr},  32'h8000);
        chk("t2_wdata", {16'd0, mem_wdata}, 32'hBEEF);
        tick();
        chk("t2_addr_hold", {16'd0, mem_addr}, 32'h8000);
        tick();
        chk("t2_d_done", {31'd0, d_done}, 32'd1);
        d_write = 1'b0; mem_ready = 1'b0;
        tick();
        chk("t2_wr_cycles", wr_hi, 32'd2);
        chk("t2_rd_cycles", rd_hi, 32'd0);

        // Both requesting continuously from reset: d,f,d,f every 3 cycles.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        f_read = 1'b1; d_read = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h00AA;
        seq = 4'b0000; ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (f_done || d_done) begin
                seq = {seq[2:0], d_done};
                ndone++;
            end
        end
        chk("t3_order", {28'd0, seq}, 32'hA);
        chk("t3_ndone", ndone, 32'd4);
        f_read = 1'b0; d_read = 1'b0; mem_ready = 1'b0;
        tick();

        // Hung data read: watchdog abort, then a fresh request is served.
        d_read = 1'b1; d_addr = 16'h4242; rd_hi = 0; n = 0;
        for (int i = 0; i < TIMEOUT + 10 && !d_done; i++) begin
            tick();
            n++;
        end
        chk("t4_d_done",  {31'd0, d_done},  32'd1);
        chk("t4_bus_err", {31'd0, bus_err}, 32'd1);
        chk("t4_d_rdata", {16'd0, d_rdata}, 32'd0);
        chk("t4_latency", n, TIMEOUT + 2);
        chk("t4_rd_cycles", rd_hi, TIMEOUT + 1);
        d_read = 1'b0;
        tick();
        f_read = 1'b1; f_addr = 16'h0100; mem_ready = 1'b1; mem_rdata = 16'h5A5A;
        for (int i = 0; i < 10 && !f_done; i++) begin
            tick();
        end
        chk("t4_next_done",  {31'd0, f_done},  32'd1);
        chk("t4_next_rdata", {16'd0, f_rdata}, 32'h5A5A);
        f_read = 1'b0; mem_ready = 1'b0;
        tick();

        // Reset during wait, then the pending fetch restarts.
        f_read = 1'b1; f_addr = 16'h0200;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        chk("t5_rd_off", {31'd0, mem_read}, 32'd0);
        chk("t5_no_done", {31'd0, f_done | d_done | bus_err}, 32'd0);
        reset = 1'b0;
        tick();
        chk("t5_restart", {31'd0, mem_read}, 32'd1);
        tick();
        mem_ready = 1'b1; mem_rdata = 16'h7777;
        tick();
        chk("t5_f_done", {31'd0, f_done}, 32'd1);
        f_read = 1'b0; mem_ready = 1'b0;
        tick();

        // Read+write together is a write; stray ready in IDLE/BEGIN is ignored.
        mem_ready = 1'b1;
        tick();
        chk("t6_stray", {31'd0, f_done | d_done}, 32'd0);
        d_read = 1'b1; d_write = 1'b1; d_addr = 16'h0C0C; d_wdata = 16'h0F0F;
        rd_hi = 0; wr_hi = 0;
        tick();
        chk("t6_write", {31'd0, mem_write}, 32'd1);
        tick();
        chk("t6_begin_ready", {31'd0, d_done}, 32'd0);
        mem_ready = 1'b0;
        tick();
        mem_ready = 1'b1;
        tick();
        chk("t6_d_done", {31'd0, d_done}, 32'd1);
        d_read = 1'b0; d_write = 1'b0; mem_ready = 1'b0;
        tick();
        chk("t6_rd_cycles", rd_hi, 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            f_read    = ($urandom_range(0, 2) != 0);
            d_read    = ($urandom_range(0, 1) != 0);
            d_write   = ($urandom_range(0, 3) == 0);
            f_addr    = 16'($urandom);
            d_addr    = 16'($urandom);
            d_wdata   = 16'($urandom);
            mem_rdata = 16'($urandom);
            mem_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0; f_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_ready = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
